// File: rtl/ls_clk_switch_if.sv
// Rate-change request channel and clock-mux control bundle
// between the request source and ls_clk_switch_ctrl.
interface ls_clk_switch_if;
    logic [1:0] bw_req;
    logic       bw_req_valid;
    logic       bw_req_ready;
    logic [1:0] spm_bw_sel;
    logic       ls_clk_en;
    logic       switch_busy;
    logic       switch_done;

    modport master (
        output bw_req,
        output bw_req_valid,
        input  bw_req_ready,
        input  spm_bw_sel,
        input  ls_clk_en,
        input  switch_busy,
        input  switch_done
    );

    modport slave (
        input  bw_req,
        input  bw_req_valid,
        output bw_req_ready,
        output spm_bw_sel,
        output ls_clk_en,
        output switch_busy,
        output switch_done
    );
endinterface

// File: rtl/ls_clk_switch_ctrl.sv
// Link-symbol clock rate switch sequencer: gate, change mux
// select, settle, re-enable. Runs on the free reference clock.
module ls_clk_switch_ctrl #(
    parameter int GATE_OFF_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 8,
    parameter int CNT_W           = 4
) (
    input logic           clk,
    input logic           rst_n,
    ls_clk_switch_if.slave sw
);

    typedef enum logic [2:0] {
        IDLE,
        GATE_OFF,
        SWITCH,
        SETTLE,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] GATE_LOAD =
        CNT_W'(GATE_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_q, en_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tgt_q   <= 2'b00;
            sel_q   <= 2'b00;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        sel_d   = sel_q;
        en_d    = en_q;
        unique case (state_q)
            IDLE: begin
                if (sw.bw_req_valid) begin
                    tgt_d = sw.bw_req;
                    if (sw.bw_req == sel_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = GATE_OFF;
                        cnt_d   = GATE_LOAD;
                        en_d    = 1'b0;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                // Select moves only while the gate is held closed.
                sel_d   = tgt_q;
                cnt_d   = SETTLE_LOAD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    en_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sw.bw_req_ready = (state_q == IDLE);
        sw.switch_busy  = (state_q != IDLE);
        sw.switch_done  = (state_q == DONE);
    end

    assign sw.spm_bw_sel = sel_q;
    assign sw.ls_clk_en  = en_q;

endmodule

// File: tb/tb_ls_clk_switch_ctrl.sv
// Bench for ls_clk_switch_ctrl: default and minimum-timing
// instances, vector table, directed corners, random traffic.
module tb_ls_clk_switch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ls_clk_switch_if if0 ();
    ls_clk_switch_if if1 ();

    ls_clk_switch_ctrl u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (if0.slave)
    );

    ls_clk_switch_ctrl #(
        .GATE_OFF_CYCLES (1),
        .SETTLE_CYCLES   (1),
        .CNT_W           (4)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (if1.slave)
    );

    logic [1:0] req [2];
    logic       vld [2];
    logic [1:0] o_sel [2];
    logic       o_en [2];
    logic       o_rdy [2];
    logic       o_busy [2];
    logic       o_done [2];

    assign if0.bw_req       = req[0];
    assign if0.bw_req_valid = vld[0];
    assign if1.bw_req       = req[1];
    assign if1.bw_req_valid = vld[1];
    assign o_sel[0]  = if0.spm_bw_sel;
    assign o_en[0]   = if0.ls_clk_en;
    assign o_rdy[0]  = if0.bw_req_ready;
    assign o_busy[0] = if0.switch_busy;
    assign o_done[0] = if0.switch_done;
    assign o_sel[1]  = if1.spm_bw_sel;
    assign o_en[1]   = if1.ls_clk_en;
    assign o_rdy[1]  = if1.bw_req_ready;
    assign o_busy[1] = if1.switch_busy;
    assign o_done[1] = if1.switch_done;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       rdy;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int         inst;
        logic [1:0] req;
        int         low;
        int         sel_at;
        int         done_at;
        int         rdy_at;
        logic [1:0] fsel;
    } vec_t;

    int n_cmp;
    int n_err;
    int cyc;

    // Transaction-level reference: one outstanding request
    // per instance, outputs derived from the accept cycle.
    bit         act  [2];
    bit         same [2];
    int         tacc [2];
    logic [1:0] tgt  [2];
    logic [1:0] base [2];
    logic [1:0] psel [2];
    logic       pen  [2];
    logic       prst [2];

    function automatic int gof(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int sof(int i);
        return (i == 0) ? 8 : 1;
    endfunction

    function automatic obs_t expect_at(int i, int now);
        obs_t e;
        int   g;
        int   s;
        int   t;
        g = gof(i);
        s = sof(i);
        t = tacc[i];
        e.sel  = base[i];
        e.en   = 1'b1;
        e.rdy  = 1'b1;
        e.busy = 1'b0;
        e.done = 1'b0;
        if (act[i]) begin
            if (same[i]) begin
                e.done = (now == t + 1);
                e.rdy  = (now >= t + 2);
            end else begin
                e.en   = !(now >= t + 1 && now <= t + g + s + 1);
                if (now >= t + g + 2) e.sel = tgt[i];
                e.done = (now == t + g + s + 2);
                e.rdy  = (now >= t + g + s + 3);
            end
            e.busy = !e.rdy;
        end
        return e;
    endfunction

    function automatic obs_t observe(int i);
        obs_t o;
        o = {o_sel[i], o_en[i], o_rdy[i], o_busy[i], o_done[i]};
        return o;
    endfunction

    task automatic chk(string nm, int got, int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, got, exp);
        end
    endtask

    task automatic run_req(input int idx, input vec_t v);
        int         low;
        int         sel_at;
        int         done_at;
        int         done_n;
        int         rdy_at;
        int         i;
        logic [1:0] p;
        low = 0; sel_at = 0; done_at = 0;
        done_n = 0; rdy_at = 0;
        i = v.inst;
        @(negedge clk);
        p = o_sel[i];
        req[i] = v.req;
        vld[i] = 1'b1;
        @(posedge clk);
        #1 vld[i] = 1'b0;
        for (int k = 1; k <= 40 && rdy_at == 0; k++) begin
            @(negedge clk);
            if (!o_en[i]) low++;
            if (o_sel[i] != p && sel_at == 0) sel_at = k;
            if (o_done[i]) begin
                done_n++;
                done_at = k;
            end
            if (o_rdy[i]) rdy_at = k;
        end
        chk($sformatf("v%0d en_low_cycles", idx), low, v.low);
        chk($sformatf("v%0d sel_change_at", idx), sel_at, v.sel_at);
        chk($sformatf("v%0d done_at", idx), done_at, v.done_at);
        chk($sformatf("v%0d done_count", idx), done_n, 1);
        chk($sformatf("v%0d ready_at", idx), rdy_at, v.rdy_at);
        chk($sformatf("v%0d final_sel", idx),
            int'(o_sel[i]), int'(v.fsel));
    endtask

    vec_t tbl [8];
    int   dn;

    initial begin
        tbl[0] = '{0, 2'b11, 13, 6, 14, 15, 2'b11};
        tbl[1] = '{0, 2'b11,  0, 0,  1,  2, 2'b11};
        tbl[2] = '{0, 2'b01, 13, 6, 14, 15, 2'b01};
        tbl[3] = '{0, 2'b00, 13, 6, 14, 15, 2'b00};
        tbl[4] = '{1, 2'b10,  3, 3,  4,  5, 2'b10};
        tbl[5] = '{1, 2'b10,  0, 0,  1,  2, 2'b10};
        tbl[6] = '{1, 2'b01,  3, 3,  4,  5, 2'b01};
        tbl[7] = '{1, 2'b00,  3, 3,  4,  5, 2'b00};

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0;  same[i] = 1'b0; tacc[i] = 0;
            tgt[i] = 2'b00; base[i] = 2'b00;
            psel[i] = 2'b00; pen[i] = 1'b1; prst[i] = 1'b0;
            req[i] = 2'b00; vld[i] = 1'b0;
        end
        rst_n = 1'b1;

        fork
            forever begin
                obs_t e;
                @(posedge clk);
                for (int i = 0; i < 2; i++) begin
                    if (!rst_n) begin
                        act[i]  = 1'b0;
                        base[i] = 2'b00;
                    end else begin
                        e = expect_at(i, cyc + 1);
                        if (act[i] && e.rdy) begin
                            base[i] = e.sel;
                            act[i]  = 1'b0;
                        end
                        if (vld[i] && e.rdy) begin
                            act[i]  = 1'b1;
                            same[i] = (req[i] == base[i]);
                            tgt[i]  = req[i];
                            tacc[i] = cyc + 1;
                        end
                    end
                end
                cyc++;
            end
            forever begin
                obs_t e;
                obs_t g;
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    g = observe(i);
                    if (!rst_n) e = {2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
                    else        e = expect_at(i, cyc + 1);
                    n_cmp++;
                    if (g !== e) begin
                        n_err++;
                        $display("FAIL model u%0d cyc %0d: got %b expected %b",
                                 i, cyc, g, e);
                    end
                    if (rst_n && prst[i]) begin
                        n_cmp++;
                        if (g.sel != psel[i] && (g.en || pen[i])) begin
                            n_err++;
                            $display("FAIL sel_moved_while_en u%0d cyc %0d: sel %0d was %0d en %0d",
                                     i, cyc, g.sel, psel[i], g.en);
                        end
                    end
                    psel[i] = g.sel;
                    pen[i]  = g.en;
                    prst[i] = rst_n;
                end
            end
        join_none

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset u%0d sel", i), int'(o_sel[i]), 0);
            chk($sformatf("reset u%0d en", i), int'(o_en[i]), 1);
            chk($sformatf("reset u%0d ready", i), int'(o_rdy[i]), 1);
            chk($sformatf("reset u%0d busy", i), int'(o_busy[i]), 0);
        end

        for (int v = 0; v < 8; v++) run_req(v, tbl[v]);

        // Reset while gated in a 00 -> 10 switch.
        @(negedge clk);
        req[0] = 2'b10;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst pre en", int'(o_en[0]), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst sel", int'(o_sel[0]), 0);
        chk("midrst en", int'(o_en[0]), 1);
        chk("midrst ready", int'(o_rdy[0]), 1);
        chk("midrst busy", int'(o_busy[0]), 0);
        chk("midrst done", int'(o_done[0]), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done[0]) dn++;
        end
        chk("midrst no_done", dn, 0);
        run_req(8, '{0, 2'b10, 13, 6, 14, 15, 2'b10});
        run_req(9, '{0, 2'b11, 13, 6, 14, 15, 2'b11});

        // 11 -> 01 with a stray request during settle.
        @(negedge clk);
        req[0] = 2'b01;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        dn = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_done[0]) dn++;
            if (k == 7) begin
                req[0] = 2'b10;
                vld[0] = 1'b1;
            end
            if (k == 9) vld[0] = 1'b0;
        end
        chk("busy_ign final_sel", int'(o_sel[0]), 1);
        chk("busy_ign done_count", dn, 1);
        chk("busy_ign ready", int'(o_rdy[0]), 1);

        repeat (600) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                req[i] = 2'($urandom_range(0, 3));
            end
        end
        @(negedge clk);
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
